amba_axi4_stream_source: RTL and testbench

AMBA_AXI4_STREAM_SOURCE -- requirements
Module: amba_axi4_stream_source

---
 rtl/amba_axi4_stream_source_pkg.sv | 32 +++
 rtl/amba_axi4_stream_source_pattern.sv | 27 ++
 rtl/amba_axi4_stream_source.sv | 177 +++++++++++++++++
 tb/tb_amba_axi4_stream_source.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/amba_axi4_stream_source_pkg.sv
// Shared types, default widths and keep-mask helper for the AXI4-Stream packet source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package amba_axi4_stream_source_pkg;

  localparam int DEF_DATA_BYTES = 4;
  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_DEST_WIDTH = 4;
  localparam int DEF_USER_WIDTH = 1;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int MAX_DATA_BYTES = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Width of the "valid bytes minus one" field; a 1-byte bus still needs one bit.
  function automatic int tail_width(input int data_bytes);
    return (data_bytes > 1) ? $clog2(data_bytes) : 1;
  endfunction

  // Bits 0..tail set, the rest clear; callers truncate to their bus width.
  function automatic logic [MAX_DATA_BYTES-1:0] last_keep_mask(input logic [5:0] tail);
    logic [MAX_DATA_BYTES-1:0] m;
    for (int i = 0; i < MAX_DATA_BYTES; i++) begin
      m[i] = (i <= int'(tail));
    end
    return m;
  endfunction

endpackage

// File: rtl/amba_axi4_stream_source_pattern.sv
// Builds one beat of incrementing-byte payload from seed, beat index and keep mask.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller registers the result only when a beat is loaded.
module amba_axi4_stream_source_pattern
  import amba_axi4_stream_source_pkg::*;
#(
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic [7:0]              seed,
  input  logic [LEN_WIDTH-1:0]    beat,
  input  logic [DATA_BYTES-1:0]   keep,
  output logic [DATA_BYTES*8-1:0] data
);

  logic [7:0] base;

  // Byte k of beat n is seed + n*DATA_BYTES + k (mod 256); dropped bytes read as zero.
  always_comb begin
    base = seed + 8'(beat * DATA_BYTES);
    data = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      data[k*8 +: 8] = keep[k] ? (base + 8'(k)) : 8'h00;
    end
  end

endmodule

// File: rtl/amba_axi4_stream_source.sv
// AXI4-Stream packet source: one command in, one packet of cmd_len+1 incrementing beats out.
// Latency: first TVALID one cycle after command accept; one idle cycle between packets.
// Backpressure: TREADY low freezes the current beat indefinitely; cmd_ready only in IDLE.
module amba_axi4_stream_source
  import amba_axi4_stream_source_pkg::*;
#(
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int DEST_WIDTH = DEF_DEST_WIDTH,
  parameter int USER_WIDTH = DEF_USER_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  localparam int TAIL_W    = tail_width(DATA_BYTES)
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [TAIL_W-1:0]       cmd_tail,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [DEST_WIDTH-1:0]   cmd_dest,
  input  logic [USER_WIDTH-1:0]   cmd_user,
  input  logic [7:0]              cmd_seed,
  output logic [DATA_BYTES*8-1:0] TDATA,
  output logic [DATA_BYTES-1:0]   TSTRB,
  output logic [DATA_BYTES-1:0]   TKEEP,
  output logic                    TLAST,
  output logic [ID_WIDTH-1:0]     TID,
  output logic [DEST_WIDTH-1:0]   TDEST,
  output logic [USER_WIDTH-1:0]   TUSER,
  output logic                    TVALID,
  input  logic                    TREADY,
  output logic                    pkt_done
);

  state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [TAIL_W-1:0]       tail_q;
  logic [7:0]              seed_q;
  logic [LEN_WIDTH-1:0]    beat_q;
  logic [LEN_WIDTH-1:0]    next_beat;

  logic                    cmd_fire;
  logic                    advance;
  logic                    last_fire;

  logic                    nxt_is_last;
  logic [7:0]              pat_seed;
  logic [LEN_WIDTH-1:0]    pat_beat;
  logic [DATA_BYTES-1:0]   pat_keep;
  logic [DATA_BYTES*8-1:0] pat_data;

  // Next-state and transfer decode; every output is registered, so TREADY never reaches TVALID combinationally.
  always_comb begin
    state_d   = state_q;
    cmd_fire  = 1'b0;
    advance   = 1'b0;
    last_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_fire = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (TVALID && TREADY) begin
          if (TLAST) begin
            last_fire = 1'b1;
            state_d   = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select what the next loaded beat looks like: beat 0 of a new command, or the following beat of this one.
  always_comb begin
    next_beat   = beat_q + LEN_WIDTH'(1);
    nxt_is_last = cmd_fire ? (cmd_len == '0) : (next_beat == len_q);
    pat_seed    = cmd_fire ? cmd_seed : seed_q;
    pat_beat    = cmd_fire ? '0 : next_beat;
    if (nxt_is_last) begin
      pat_keep = DATA_BYTES'(last_keep_mask(cmd_fire ? 6'(cmd_tail) : 6'(tail_q)));
    end else begin
      pat_keep = {DATA_BYTES{1'b1}};
    end
  end

  amba_axi4_stream_source_pattern #(
    .DATA_BYTES (DATA_BYTES),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_pattern (
    .seed (pat_seed),
    .beat (pat_beat),
    .keep (pat_keep),
    .data (pat_data)
  );

  // State register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // cmd_ready follows IDLE one cycle late, which blocks acceptance in the last-beat cycle and right out of reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cmd_ready <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      cmd_ready <= (state_d == IDLE);
      pkt_done  <= last_fire;
    end
  end

  // Hold the command fields for the whole packet.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      len_q  <= '0;
      tail_q <= '0;
      seed_q <= '0;
    end else if (cmd_fire) begin
      len_q  <= cmd_len;
      tail_q <= cmd_tail;
      seed_q <= cmd_seed;
    end
  end

  // Beat counter and stream output registers; they only move on accept, handshake, or end of packet.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      beat_q <= '0;
      TVALID <= 1'b0;
      TLAST  <= 1'b0;
      TDATA  <= '0;
      TKEEP  <= '0;
      TSTRB  <= '0;
      TID    <= '0;
      TDEST  <= '0;
      TUSER  <= '0;
    end else if (cmd_fire) begin
      beat_q <= '0;
      TVALID <= 1'b1;
      TLAST  <= nxt_is_last;
      TDATA  <= pat_data;
      TKEEP  <= pat_keep;
      TSTRB  <= pat_keep;
      TID    <= cmd_id;
      TDEST  <= cmd_dest;
      TUSER  <= cmd_user;
    end else if (advance) begin
      beat_q <= next_beat;
      TLAST  <= nxt_is_last;
      TDATA  <= pat_data;
      TKEEP  <= pat_keep;
      TSTRB  <= pat_keep;
    end else if (last_fire) begin
      beat_q <= '0;
      TVALID <= 1'b0;
      TLAST  <= 1'b0;
      TDATA  <= '0;
      TKEEP  <= '0;
      TSTRB  <= '0;
      TID    <= '0;
      TDEST  <= '0;
      TUSER  <= '0;
    end
  end

endmodule

// File: tb/tb_amba_axi4_stream_source.sv
// Directed bench for the AXI4-Stream packet source with a stream-stability monitor.
// Latency: checks 1-cycle accept-to-TVALID and one idle cycle between packets.
// Backpressure: exercises TREADY stalls and TREADY toggling while TVALID is low.
module tb_amba_axi4_stream_source;

  logic        ACLK;
  logic        ARESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_tail;
  logic [3:0]  cmd_id;
  logic [3:0]  cmd_dest;
  logic [0:0]  cmd_user;
  logic [7:0]  cmd_seed;
  logic [31:0] TDATA;
  logic [3:0]  TSTRB;
  logic [3:0]  TKEEP;
  logic        TLAST;
  logic [3:0]  TID;
  logic [3:0]  TDEST;
  logic [0:0]  TUSER;
  logic        TVALID;
  logic        TREADY;
  logic        pkt_done;

  int n_cmp;
  int n_bad;
  int prot_err;

  amba_axi4_stream_source dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_tail  (cmd_tail),
    .cmd_id    (cmd_id),
    .cmd_dest  (cmd_dest),
    .cmd_user  (cmd_user),
    .cmd_seed  (cmd_seed),
    .TDATA     (TDATA),
    .TSTRB     (TSTRB),
    .TKEEP     (TKEEP),
    .TLAST     (TLAST),
    .TID       (TID),
    .TDEST     (TDEST),
    .TUSER     (TUSER),
    .TVALID    (TVALID),
    .TREADY    (TREADY),
    .pkt_done  (pkt_done)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Stream monitor: a stalled beat must stay valid and unchanged, and TSTRB must track TKEEP.
  logic        p_v, p_r, p_l, p_rst;
  logic [31:0] p_d;
  logic [3:0]  p_k, p_id, p_de;
  logic [0:0]  p_u;
  initial begin
    p_v = 1'b0; p_r = 1'b0; p_l = 1'b0; p_rst = 1'b1;
    p_d = '0; p_k = '0; p_id = '0; p_de = '0; p_u = '0;
    prot_err = 0;
  end
  always begin
    @(negedge ACLK);
    #1;
    if (!ARESET && !p_rst && p_v && !p_r) begin
      if (TVALID !== 1'b1 || TDATA !== p_d || TKEEP !== p_k || TLAST !== p_l ||
          TID !== p_id || TDEST !== p_de || TUSER !== p_u) begin
        prot_err++;
        $display("protocol: stalled beat changed at %0t", $time);
      end
    end
    if (!ARESET && TVALID === 1'b1 && TSTRB !== TKEEP) begin
      prot_err++;
      $display("protocol: TSTRB differs from TKEEP at %0t", $time);
    end
    p_v = TVALID; p_r = TREADY; p_l = TLAST; p_rst = ARESET;
    p_d = TDATA; p_k = TKEEP; p_id = TID; p_de = TDEST; p_u = TUSER;
  end

  // Present a command at a negedge and hold it until accepted; returns at the negedge after acceptance.
  task automatic issue(input logic [7:0] len, input logic [1:0] tail, input logic [7:0] seed,
                       input logic [3:0] id, input logic [3:0] dest, input logic [0:0] user,
                       output bit ok);
    ok = 1'b0;
    cmd_len = len; cmd_tail = tail; cmd_seed = seed;
    cmd_id = id; cmd_dest = dest; cmd_user = user;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge ACLK);
    end
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    n_cmp++; if (TVALID !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b want 0", TVALID); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    n_cmp++; if (pkt_done !== 1'b0) begin n_bad++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
    n_cmp++; if (TLAST !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %b want 0", TLAST); end
    n_cmp++; if (TDATA !== 32'h0 || TKEEP !== 4'h0) begin n_bad++; $display("FAIL reset_payload: got %h/%h want 0/0", TDATA, TKEEP); end
    ARESET = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_edge: got %b want 0", cmd_ready); end
    @(negedge ACLK);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_edge: got %b want 1", cmd_ready); end
    n_cmp++; if (TVALID !== 1'b0) begin n_bad++; $display("FAIL idle_tvalid: got %b want 0", TVALID); end
  endtask

  task automatic test_basic_packet();
    logic [31:0] exp_d [0:3];
    logic [3:0]  exp_k [0:3];
    bit ok;
    exp_d[0] = 32'h13121110; exp_k[0] = 4'hF;
    exp_d[1] = 32'h17161514; exp_k[1] = 4'hF;
    exp_d[2] = 32'h1B1A1918; exp_k[2] = 4'hF;
    exp_d[3] = 32'h00001D1C; exp_k[3] = 4'h3;
    TREADY = 1'b1;
    issue(8'd3, 2'd1, 8'h10, 4'hA, 4'h5, 1'b1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_accept: got %b want 1", ok); end
    for (int b = 0; b < 4; b++) begin
      n_cmp++; if (TVALID !== 1'b1) begin n_bad++; $display("FAIL basic_tvalid[%0d]: got %b want 1", b, TVALID); end
      n_cmp++; if (TDATA !== exp_d[b]) begin n_bad++; $display("FAIL basic_tdata[%0d]: got %h want %h", b, TDATA, exp_d[b]); end
      n_cmp++; if (TKEEP !== exp_k[b] || TSTRB !== exp_k[b]) begin n_bad++; $display("FAIL basic_keep[%0d]: got %h/%h want %h", b, TKEEP, TSTRB, exp_k[b]); end
      n_cmp++; if (TLAST !== (b == 3)) begin n_bad++; $display("FAIL basic_tlast[%0d]: got %b want %b", b, TLAST, (b == 3)); end
      n_cmp++; if (TID !== 4'hA || TDEST !== 4'h5 || TUSER !== 1'b1) begin n_bad++; $display("FAIL basic_side[%0d]: got %h/%h/%h want a/5/1", b, TID, TDEST, TUSER); end
      n_cmp++; if (cmd_ready !== 1'b0 || pkt_done !== 1'b0) begin n_bad++; $display("FAIL basic_busy[%0d]: got rdy %b done %b want 0 0", b, cmd_ready, pkt_done); end
      @(negedge ACLK);
    end
    n_cmp++; if (TVALID !== 1'b0) begin n_bad++; $display("FAIL basic_end_tvalid: got %b want 0", TVALID); end
    n_cmp++; if (pkt_done !== 1'b1) begin n_bad++; $display("FAIL basic_pkt_done: got %b want 1", pkt_done); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_back: got %b want 1", cmd_ready); end
    @(negedge ACLK);
    n_cmp++; if (pkt_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b want 0", pkt_done); end
  endtask

  task automatic test_single_beat();
    bit ok;
    TREADY = 1'b1;
    issue(8'd0, 2'd3, 8'hFE, 4'h2, 4'h3, 1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_accept: got %b want 1", ok); end
    n_cmp++; if (TVALID !== 1'b1 || TLAST !== 1'b1) begin n_bad++; $display("FAIL single_flags: got v%b l%b want v1 l1", TVALID, TLAST); end
    n_cmp++; if (TDATA !== 32'h0100FFFE) begin n_bad++; $display("FAIL single_tdata: got %h want 0100fffe", TDATA); end
    n_cmp++; if (TKEEP !== 4'hF) begin n_bad++; $display("FAIL single_tkeep: got %h want f", TKEEP); end
    @(negedge ACLK);
    n_cmp++; if (TVALID !== 1'b0 || pkt_done !== 1'b1) begin n_bad++; $display("FAIL single_end: got v%b done%b want v0 done1", TVALID, pkt_done); end
    @(negedge ACLK);
  endtask

  task automatic test_stall();
    logic [31:0] exp_d [0:2];
    bit ok;
    exp_d[0] = 32'h43424140;
    exp_d[1] = 32'h47464544;
    exp_d[2] = 32'h4B4A4948;
    TREADY = 1'b0;
    issue(8'd2, 2'd3, 8'h40, 4'h7, 4'h8, 1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stall_accept: got %b want 1", ok); end
    for (int b = 0; b < 3; b++) begin
      for (int s = 0; s < 6; s++) begin
        TREADY = (s == 5);
        n_cmp++; if (TVALID !== 1'b1) begin n_bad++; $display("FAIL stall_tvalid[%0d.%0d]: got %b want 1", b, s, TVALID); end
        n_cmp++; if (TDATA !== exp_d[b]) begin n_bad++; $display("FAIL stall_tdata[%0d.%0d]: got %h want %h", b, s, TDATA, exp_d[b]); end
        n_cmp++; if (TLAST !== (b == 2)) begin n_bad++; $display("FAIL stall_tlast[%0d.%0d]: got %b want %b", b, s, TLAST, (b == 2)); end
        @(negedge ACLK);
      end
    end
    TREADY = 1'b1;
    n_cmp++; if (TVALID !== 1'b0 || pkt_done !== 1'b1) begin n_bad++; $display("FAIL stall_end: got v%b done%b want v0 done1", TVALID, pkt_done); end
    @(negedge ACLK);
  endtask

  task automatic test_reset_midpacket();
    bit ok;
    TREADY = 1'b1;
    issue(8'd7, 2'd3, 8'h80, 4'h4, 4'h4, 1'b0, ok);
    n_cmp++; if (TDATA !== 32'h83828180) begin n_bad++; $display("FAIL mid_beat0: got %h want 83828180", TDATA); end
    @(negedge ACLK);
    n_cmp++; if (TDATA !== 32'h87868584 || TVALID !== 1'b1) begin n_bad++; $display("FAIL mid_beat1: got %h v%b want 87868584 v1", TDATA, TVALID); end
    ARESET = 1'b1;
    #1;
    n_cmp++; if (TVALID !== 1'b0 || TLAST !== 1'b0 || cmd_ready !== 1'b0 || pkt_done !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags: got v%b l%b r%b d%b want 0000", TVALID, TLAST, cmd_ready, pkt_done); end
    n_cmp++; if (TDATA !== 32'h0 || TKEEP !== 4'h0 || TID !== 4'h0) begin n_bad++; $display("FAIL mid_reset_payload: got %h/%h/%h want 0/0/0", TDATA, TKEEP, TID); end
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    n_cmp++; if (cmd_ready !== 1'b1 || TVALID !== 1'b0) begin n_bad++; $display("FAIL mid_recover: got r%b v%b want r1 v0", cmd_ready, TVALID); end
    issue(8'd1, 2'd0, 8'h20, 4'h3, 4'h9, 1'b1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL mid_accept: got %b want 1", ok); end
    n_cmp++; if (TDATA !== 32'h23222120 || TKEEP !== 4'hF || TLAST !== 1'b0) begin n_bad++; $display("FAIL mid_new_beat0: got %h/%h/%b want 23222120/f/0", TDATA, TKEEP, TLAST); end
    n_cmp++; if (TID !== 4'h3 || TDEST !== 4'h9 || TUSER !== 1'b1) begin n_bad++; $display("FAIL mid_new_side: got %h/%h/%h want 3/9/1", TID, TDEST, TUSER); end
    @(negedge ACLK);
    n_cmp++; if (TDATA !== 32'h00000024 || TKEEP !== 4'h1 || TLAST !== 1'b1) begin n_bad++; $display("FAIL mid_new_beat1: got %h/%h/%b want 00000024/1/1", TDATA, TKEEP, TLAST); end
    @(negedge ACLK);
    n_cmp++; if (pkt_done !== 1'b1 || TVALID !== 1'b0) begin n_bad++; $display("FAIL mid_new_done: got d%b v%b want d1 v0", pkt_done, TVALID); end
    @(negedge ACLK);
  endtask

  task automatic test_back_to_back();
    TREADY = 1'b1;
    cmd_len = 8'd1; cmd_tail = 2'd3; cmd_seed = 8'h00;
    cmd_id = 4'h1; cmd_dest = 4'h2; cmd_user = 1'b0;
    cmd_valid = 1'b1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready0: got %b want 1", cmd_ready); end
    @(negedge ACLK);
    n_cmp++; if (TVALID !== 1'b1 || TID !== 4'h1 || TDATA !== 32'h03020100 || TLAST !== 1'b0) begin n_bad++; $display("FAIL b2b_a0: got v%b id%h %h l%b want v1 id1 03020100 l0", TVALID, TID, TDATA, TLAST); end
    cmd_len = 8'd0; cmd_tail = 2'd1; cmd_seed = 8'h55;
    cmd_id = 4'h5; cmd_dest = 4'h6; cmd_user = 1'b1;
    @(negedge ACLK);
    n_cmp++; if (TVALID !== 1'b1 || TID !== 4'h1 || TDEST !== 4'h2 || TDATA !== 32'h07060504 || TLAST !== 1'b1) begin n_bad++; $display("FAIL b2b_a1: got v%b id%h de%h %h l%b want v1 id1 de2 07060504 l1", TVALID, TID, TDEST, TDATA, TLAST); end
    @(negedge ACLK);
    n_cmp++; if (TVALID !== 1'b0 || pkt_done !== 1'b1 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_gap: got v%b d%b r%b want v0 d1 r1", TVALID, pkt_done, cmd_ready); end
    @(negedge ACLK);
    n_cmp++; if (TVALID !== 1'b1 || TID !== 4'h5 || TDEST !== 4'h6 || TDATA !== 32'h00005655 || TKEEP !== 4'h3 || TLAST !== 1'b1) begin n_bad++; $display("FAIL b2b_b0: got v%b id%h de%h %h k%h l%b want v1 id5 de6 00005655 k3 l1", TVALID, TID, TDEST, TDATA, TKEEP, TLAST); end
    cmd_valid = 1'b0;
    @(negedge ACLK);
    n_cmp++; if (TVALID !== 1'b0 || pkt_done !== 1'b1) begin n_bad++; $display("FAIL b2b_b_done: got v%b d%b want v0 d1", TVALID, pkt_done); end
    @(negedge ACLK);
    n_cmp++; if (TVALID !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle: got v%b r%b want v0 r1", TVALID, cmd_ready); end
  endtask

  task automatic test_protocol();
    n_cmp++; if (prot_err !== 0) begin n_bad++; $display("FAIL protocol_monitor: got %0d errors want 0", prot_err); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ARESET = 1'b1;
    cmd_valid = 1'b0;
    cmd_len = '0; cmd_tail = '0; cmd_seed = '0;
    cmd_id = '0; cmd_dest = '0; cmd_user = '0;
    TREADY = 1'b0;
    test_reset();
    test_basic_packet();
    test_single_beat();
    test_stall();
    test_reset_midpacket();
    test_back_to_back();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
